// File: rtl/tc_sm_stream_pkg.sv
// tc_sm_stream_pkg: mode encodings and default widths for the sign-magnitude stream converter.
package tc_sm_stream_pkg;
  localparam logic MODE_TC2SM = 1'b0;
  localparam logic MODE_SM2TC = 1'b1;
  localparam int W_DEFAULT = 12;
  localparam int CW_DEFAULT = 8;
endpackage

// File: rtl/tc_sm_stream_conv.sv
// sm_tc_conv: combinational two's complement <-> sign-magnitude converter.
module sm_tc_conv
  import tc_sm_stream_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] data,
  input  logic         mode,
  output logic [W-1:0] result,
  output logic         flag
);
  logic         sign;
  logic [W-1:0] mag;
  logic [W-1:0] neg_mag;
  logic [W-2:0] neg_low;
  assign sign    = data[W-1];
  assign mag     = {1'b0, data[W-2:0]};
  assign neg_mag = (~mag) + W'(1);
  assign neg_low = (~data[W-2:0]) + (W-1)'(1);
  // Most-negative input (mode 0) and negative zero (mode 1) share the same bit pattern.
  assign flag    = sign && (data[W-2:0] == '0);
  always_comb begin
    result = !sign ? mag
           : (mode == MODE_TC2SM) ? (flag ? {W{1'b1}} : {1'b1, neg_low})
           : (flag ? {W{1'b0}} : neg_mag);
  end
endmodule

// File: rtl/tc_sm_stream.sv
// tc_sm_stream: two-stage valid/ready pipeline converting between two's complement
// and sign-magnitude, with a saturating count of flagged results delivered.
module tc_sm_stream
  import tc_sm_stream_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_flag,
  output logic [CW-1:0] sat_cnt
);
  logic         adv;
  logic         s1_valid;
  logic         s1_mode;
  logic [W-1:0] s1_data;
  logic [W-1:0] conv_data;
  logic         conv_flag;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  sm_tc_conv #(.W(W)) u_conv (
    .data  (s1_data),
    .mode  (s1_mode),
    .result(conv_data),
    .flag  (conv_flag)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_TC2SM;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flag  <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (adv) begin
        s1_valid  <= in_valid;
        out_valid <= s1_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_mode <= in_mode;
        end
        if (s1_valid) begin
          out_data <= conv_data;
          out_flag <= conv_flag;
        end
      end
      if (out_valid && out_ready && out_flag && sat_cnt != '1)
        sat_cnt <= sat_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_tc_sm_stream.sv
// tb_tc_sm_stream: directed vector table plus stall, mixed-mode, reset and counter sequences.
module tb_tc_sm_stream;
  import tc_sm_stream_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_flag;
  logic [11:0] out_data;
  logic [7:0]  sat_cnt;
  logic        in_ready2, out_valid2, out_flag2;
  logic [11:0] out_data2;
  logic [1:0]  sat_cnt2;
  int checks = 0;
  int errors = 0;
  int mon_rcv = 0;
  logic mon_en = 1'b0;
  logic [12:0] exp_q[$];
  logic        st_mode[4];
  logic [11:0] st_data[4];
  typedef struct {
    logic        mode;
    logic [11:0] din;
    logic [11:0] dout;
    logic        flag;
  } vec_t;
  vec_t vecs[11];

  tc_sm_stream #(.W(12), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flag(out_flag), .sat_cnt(sat_cnt)
  );
  tc_sm_stream #(.W(12), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_flag(out_flag2), .sat_cnt(sat_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", {19'd0, out_flag, out_data}, 32'hdead);
      else begin
        check("stream_word", {19'd0, out_flag, out_data}, {19'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
      mon_rcv++;
    end
  end

  task automatic run_stream(input int n, input int lo, input int hi, output int cyc);
    int i = 0;
    logic acc;
    cyc = 0;
    mon_rcv = 0;
    mon_en = 1'b1;
    while (mon_rcv < n && cyc < 40) begin
      out_ready = !(cyc >= lo && cyc < hi);
      in_valid  = i < n;
      in_data   = st_data[i < n ? i : 0];
      in_mode   = st_mode[i < n ? i : 0];
      #1;
      if (!out_ready && out_valid) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() != 0) check("stall_hold", {20'd0, out_data}, {20'd0, exp_q[0][11:0]});
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    mon_en = 1'b0;
    check("stream_count", mon_rcv, n);
    check("stream_leftover", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int exp_sat;
    vecs[0]  = '{MODE_TC2SM, 12'hFFF, 12'h801, 1'b0};
    vecs[1]  = '{MODE_TC2SM, 12'h800, 12'hFFF, 1'b1};
    vecs[2]  = '{MODE_SM2TC, 12'h800, 12'h000, 1'b1};
    vecs[3]  = '{MODE_SM2TC, 12'h805, 12'hFFB, 1'b0};
    vecs[4]  = '{MODE_TC2SM, 12'h000, 12'h000, 1'b0};
    vecs[5]  = '{MODE_TC2SM, 12'h7FF, 12'h7FF, 1'b0};
    vecs[6]  = '{MODE_TC2SM, 12'h801, 12'hFFF, 1'b0};
    vecs[7]  = '{MODE_SM2TC, 12'hFFF, 12'h801, 1'b0};
    vecs[8]  = '{MODE_SM2TC, 12'h7FF, 12'h7FF, 1'b0};
    vecs[9]  = '{MODE_SM2TC, 12'h001, 12'h001, 1'b0};
    vecs[10] = '{MODE_TC2SM, 12'hF00, 12'h900, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {20'd0, out_data}, 32'd0);
    check("rst_out_flag", {31'd0, out_flag}, 32'd0);
    check("rst_sat_cnt", {24'd0, sat_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    exp_sat = 0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      in_mode  = vecs[k].mode;
      in_data  = vecs[k].din;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_latency", k), {31'd0, out_valid}, 32'd0);
      tick();
      check($sformatf("v%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("v%0d_data", k), {20'd0, out_data}, {20'd0, vecs[k].dout});
      check($sformatf("v%0d_flag", k), {31'd0, out_flag}, {31'd0, vecs[k].flag});
      tick();
      exp_sat += int'(vecs[k].flag);
      check($sformatf("v%0d_sat", k), {24'd0, sat_cnt}, exp_sat);
      check($sformatf("v%0d_drained", k), {31'd0, out_valid}, 32'd0);
    end

    st_mode = '{MODE_TC2SM, MODE_TC2SM, MODE_TC2SM, MODE_TC2SM};
    st_data = '{12'h001, 12'h7FF, 12'h800, 12'hF00};
    exp_q = '{13'h0001, 13'h07FF, 13'h1FFF, 13'h0900};
    run_stream(4, 2, 5, cyc);
    exp_sat += 1;
    check("stall_sat", {24'd0, sat_cnt}, exp_sat);

    st_mode = '{MODE_SM2TC, MODE_TC2SM, MODE_SM2TC, MODE_TC2SM};
    st_data = '{12'h805, 12'h800, 12'h800, 12'hF00};
    exp_q = '{13'h0FFB, 13'h1FFF, 13'h1000, 13'h0900};
    run_stream(4, 0, 0, cyc);
    check("throughput_cycles", cyc, 6);

    in_valid = 1'b1; in_mode = MODE_TC2SM; in_data = 12'h800;
    tick();
    in_data = 12'h123;
    tick();
    in_valid = 1'b0;
    check("inflight_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_sat_cnt", {24'd0, sat_cnt}, 32'd0);
    check("async_sat_cnt2", {30'd0, sat_cnt2}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("no_stale_%0d", k), {31'd0, out_valid}, 32'd0);
    end

    for (int k = 0; k < 7; k++) begin
      in_valid = k < 5;
      in_mode = MODE_TC2SM;
      in_data = 12'h800;
      tick();
      if (k == 0) check("rst_first_latency", {31'd0, out_valid}, 32'd0);
      if (k == 1) check("rst_first_data", {19'd0, out_flag, out_data}, 32'h1FFF);
      if (k >= 2) begin
        check($sformatf("sat2_%0d", k - 1), {30'd0, sat_cnt2}, (k - 1 > 3) ? 3 : k - 1);
        check($sformatf("sat8_%0d", k - 1), {24'd0, sat_cnt}, k - 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
